// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN window reader slice.
package cnn_pkg;

   localparam int unsigned data_width = 32;

   function automatic int unsigned out_dim(input int unsigned input_size,
                                           input int unsigned filter,
                                           input int unsigned stride);
      return (input_size - filter) / stride + 1;
   endfunction

   typedef enum logic {
      StLoad = 1'b0,
      StScan = 1'b1
   } cnn_state_e;

endpackage

// File: rtl/cnn_image_buffer.sv
// Frame store: one synchronous write port and a full filter-window of combinational read taps.
module cnn_image_buffer
   import cnn_pkg::*;
#(
   parameter int unsigned input_size      = 28,
   parameter int unsigned cnn_filter_size = 3,
   parameter int unsigned data_width      = cnn_pkg::data_width,
   localparam int unsigned pix            = input_size * input_size,
   localparam int unsigned taps           = cnn_filter_size * cnn_filter_size,
   localparam int unsigned addr_w         = $clog2(pix)
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [addr_w-1:0]          wr_addr,
   input  logic [data_width-1:0]      wr_data,
   input  logic [addr_w-1:0]          rd_base,
   output logic [taps*data_width-1:0] rd_data
);

   logic [data_width-1:0] mem [pix];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar k = 0; k < taps; k++) begin : g_tap
      localparam int unsigned off = (k / cnn_filter_size) * input_size + (k % cnn_filter_size);
      logic [addr_w-1:0] addr;
      assign addr = rd_base + addr_w'(off);
      // Forward a same-cycle write so the first window can be captured on the last load edge.
      assign rd_data[k*data_width +: data_width] = (we && (wr_addr == addr)) ? wr_data : mem[addr];
   end

endmodule

// File: rtl/cnn_window_reader.sv
// Loads one raster-order frame, then streams stride-spaced filter windows from it.
module cnn_window_reader
   import cnn_pkg::*;
#(
   parameter int unsigned input_size      = 28,
   parameter int unsigned cnn_filter_size = 3,
   parameter int unsigned cnn_stride      = 2,
   parameter int unsigned data_width      = cnn_pkg::data_width,
   localparam int unsigned od             = out_dim(input_size, cnn_filter_size, cnn_stride),
   localparam int unsigned rc_w           = (od > 1) ? $clog2(od) : 1,
   localparam int unsigned pix            = input_size * input_size,
   localparam int unsigned addr_w         = $clog2(pix),
   localparam int unsigned win_w          = cnn_filter_size * cnn_filter_size * data_width
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [win_w-1:0]      win_data,
   output logic [rc_w-1:0]       win_row,
   output logic [rc_w-1:0]       win_col,
   output logic                  win_last,
   output logic                  frame_done
);

   localparam logic [rc_w-1:0]   rc_max  = rc_w'(od - 1);
   localparam logic [addr_w-1:0] ptr_max = addr_w'(pix - 1);

   cnn_state_e        state_q;
   logic [addr_w-1:0] wr_ptr_q;
   logic [rc_w-1:0]   row_q, col_q, row_d, col_d;
   logic              valid_q, last_q, done_q, next_last;
   logic [win_w-1:0]  win_q, rd_data;
   logic [addr_w-1:0] rd_base;
   logic              in_fire, load_end, win_fire;

   assign in_ready  = rstb && (state_q == StLoad);
   assign in_fire   = in_valid && in_ready;
   assign load_end  = in_fire && (wr_ptr_q == ptr_max);
   assign win_fire  = valid_q && win_ready;

   assign win_valid  = valid_q;
   assign win_data   = win_q;
   assign win_row    = row_q;
   assign win_col    = col_q;
   assign win_last   = last_q;
   assign frame_done = done_q;

   // Position of the window that will be on the outputs after this edge.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (win_fire) begin
         if (col_q == rc_max) begin
            col_d = '0;
            row_d = last_q ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      next_last = (row_d == rc_max) && (col_d == rc_max);
      rd_base   = addr_w'(32'(row_d) * cnn_stride * input_size + 32'(col_d) * cnn_stride);
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q  <= StLoad;
         wr_ptr_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StLoad: begin
               if (load_end) begin
                  wr_ptr_q <= '0;
                  state_q  <= StScan;
                  valid_q  <= 1'b1;
                  last_q   <= next_last;
               end else if (in_fire) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
               end
            end
            StScan: begin
               if (win_fire) begin
                  row_q  <= row_d;
                  col_q  <= col_d;
                  last_q <= next_last;
                  if (last_q) begin
                     state_q <= StLoad;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   // Window payload is a plain data register; it only changes when a new window is presented.
   always_ff @(posedge clk) begin
      if (load_end || (win_fire && !last_q)) begin
         win_q <= rd_data;
      end
   end

   cnn_image_buffer #(
      .input_size      (input_size),
      .cnn_filter_size (cnn_filter_size),
      .data_width      (data_width)
   ) u_buf (
      .clk     (clk),
      .we      (in_fire),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_base (rd_base),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_cnn_window_reader.sv
// Directed bench for cnn_window_reader with a window scoreboard fed from a pixel-value model.
module tb_cnn_window_reader;

   localparam int unsigned isz  = 28;
   localparam int unsigned st   = 2;
   localparam int unsigned dw   = 32;
   localparam int unsigned od   = 13;
   localparam int unsigned ww   = 9 * dw;
   localparam int unsigned npix = isz * isz;
   localparam int unsigned nwin = od * od;

   typedef struct packed {
      logic [ww-1:0] data;
      logic [3:0]    row;
      logic [3:0]    col;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          in_valid = 1'b0;
   logic          win_ready = 1'b0;
   logic [dw-1:0] in_data = '0;
   logic          in_ready, win_valid, win_last, frame_done;
   logic [ww-1:0] win_data;
   logic [3:0]    win_row, win_col;

   always #5 clk = ~clk;

   cnn_window_reader dut (
      .clk        (clk),
      .rstb       (rstb),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_last   (win_last),
      .frame_done (frame_done)
   );

   int unsigned   checks = 0;
   int unsigned   passed = 0;
   int unsigned   n_win = 0;
   int unsigned   done_seen = 0;
   exp_t          q[$];
   logic [ww-1:0] cap [nwin];
   logic          prev_stall = 1'b0;
   logic          prev_last_hs = 1'b0;
   logic [ww-1:0] prev_data = '0;
   logic [3:0]    prev_row = '0;
   logic [3:0]    prev_col = '0;

   task automatic chk(input string tag, input logic [ww-1:0] obs, input logic [ww-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [ww-1:0] model_win(input int unsigned b, input int unsigned r,
                                               input int unsigned c);
      logic [ww-1:0] w = '0;
      for (int ky = 0; ky < 3; ky++) begin
         for (int kx = 0; kx < 3; kx++) begin
            w[(ky*3+kx)*dw +: dw] = b + (r * st + ky) * isz + c * st + kx;
         end
      end
      return w;
   endfunction

   task automatic push_frame(input int unsigned b);
      exp_t e;
      for (int r = 0; r < od; r++) begin
         for (int c = 0; c < od; c++) begin
            e.data = model_win(b, r, c);
            e.row  = 4'(r);
            e.col  = 4'(c);
            e.last = (r == od - 1) && (c == od - 1);
            q.push_back(e);
         end
      end
   endtask

   // Sampled on the falling edge: judges the handshake that the next rising edge commits.
   task automatic monitor();
      exp_t e;
      if (!rstb) begin
         q.delete();
         n_win        = 0;
         prev_stall   = 1'b0;
         prev_last_hs = 1'b0;
         return;
      end
      if (frame_done || prev_last_hs) begin
         chk("frame_done_pulse", frame_done, prev_last_hs);
         if (frame_done) begin
            chk("done_in_ready", in_ready, 1'b1);
            chk("done_win_count", n_win, nwin);
            chk("done_queue_empty", q.size(), 0);
            n_win = 0;
            done_seen++;
         end
      end
      if (win_valid) chk("scan_in_ready", in_ready, 1'b0);
      if (win_valid && prev_stall) begin
         chk("stall_data", win_data, prev_data);
         chk("stall_row", win_row, prev_row);
         chk("stall_col", win_col, prev_col);
      end
      prev_last_hs = win_valid && win_ready && win_last;
      prev_stall   = win_valid && !win_ready;
      prev_data    = win_data;
      prev_row     = win_row;
      prev_col     = win_col;
      if (win_valid && win_ready) begin
         if (q.size() == 0) begin
            chk("spare_window", win_valid, 1'b0);
         end else begin
            e = q.pop_front();
            chk("win_data", win_data, e.data);
            chk("win_row", win_row, e.row);
            chk("win_col", win_col, e.col);
            chk("win_last", win_last, e.last);
         end
         if (win_row < od && win_col < od) cap[win_row*od+win_col] = win_data;
         n_win++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstb     = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_win_last", win_last, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_win_row", win_row, 4'd0);
      chk("rst_win_col", win_col, 4'd0);
      rstb = 1'b1;
      #1;
      chk("ready_after_reset", in_ready, 1'b1);
   endtask

   task automatic send_pixels(input int unsigned b, input int unsigned n, input int unsigned gap);
      int unsigned sent = 0;
      int unsigned cyc = 0;
      logic        early = 1'b0;
      if (n == npix) push_frame(b);
      while (sent < n && cyc < n * gap + 10) begin
         in_valid = (cyc % gap) == 0;
         in_data  = b + sent;
         if (win_valid) early = 1'b1;
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      chk("load_count", sent, n);
      chk("no_early_window", early, 1'b0);
      if (n == npix) begin
         chk("first_valid", win_valid, 1'b1);
         chk("first_row", win_row, 4'd0);
         chk("first_col", win_col, 4'd0);
      end
   endtask

   task automatic run_scan(input logic bp, input logic junk, input int unsigned stop_at,
                           output logic stopped);
      int unsigned start = done_seen;
      int unsigned cyc = 0;
      stopped = 1'b0;
      while (done_seen == start && cyc < 4000) begin
         win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid  = junk && win_valid;
         in_data   = 32'hDEAD_BEEF;
         tick();
         cyc++;
         if (stop_at > 0 && n_win == stop_at) begin
            stopped = 1'b1;
            break;
         end
      end
      in_valid  = 1'b0;
      win_ready = 1'b1;
      if (!stopped) chk("scan_complete", done_seen, start + 1);
   endtask

   initial begin
      logic stopped;
      do_reset();
      win_ready = 1'b1;

      // Basic frame
      send_pixels(0, npix, 1);
      run_scan(1'b0, 1'b0, 0, stopped);
      chk("win_0_0", cap[0],
          {32'd58, 32'd57, 32'd56, 32'd30, 32'd29, 32'd28, 32'd2, 32'd1, 32'd0});
      chk("win_0_1", cap[1],
          {32'd60, 32'd59, 32'd58, 32'd32, 32'd31, 32'd30, 32'd4, 32'd3, 32'd2});
      chk("win_12_12", cap[nwin-1],
          {32'd754, 32'd753, 32'd752, 32'd726, 32'd725, 32'd724, 32'd698, 32'd697, 32'd696});

      // Backpressure
      send_pixels(0, npix, 1);
      run_scan(1'b1, 1'b0, 0, stopped);

      // Input gaps
      send_pixels(0, npix, 3);
      run_scan(1'b0, 1'b0, 0, stopped);

      // Input ignored during scan, then a new frame
      send_pixels(0, npix, 1);
      run_scan(1'b0, 1'b1, 0, stopped);
      send_pixels(1000, npix, 1);
      run_scan(1'b0, 1'b0, 0, stopped);
      chk("win_0_0_frame1000", cap[0],
          {32'd1058, 32'd1057, 32'd1056, 32'd1030, 32'd1029, 32'd1028,
           32'd1002, 32'd1001, 32'd1000});

      // Reset mid-scan after window (3,5)
      send_pixels(5000, npix, 1);
      run_scan(1'b0, 1'b0, 3 * od + 5 + 1, stopped);
      chk("reached_win_3_5", stopped, 1'b1);
      do_reset();
      send_pixels(2000, npix, 1);
      run_scan(1'b0, 1'b0, 0, stopped);
      chk("win_0_0_after_reset", cap[0], model_win(2000, 0, 0));

      // Reset mid-load
      send_pixels(3000, 400, 1);
      do_reset();
      send_pixels(4000, npix, 1);
      run_scan(1'b0, 1'b0, 0, stopped);
      chk("win_0_0_after_load_reset", cap[0], model_win(4000, 0, 0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cnn_window_reader.md
# cnn_window_reader

Streaming front end for the CNN convolution stage. Accepts one image as a raster-order stream of 32-bit pixels over a valid/ready handshake and stores it in an internal frame buffer. Once the frame is complete, it reads the buffer back as stride-`cnn_stride` `cnn_filter_size`×`cnn_filter_size` windows, one window per handshake. It is the reader side of the image store the convolution datapath consumes.

## Interface

**Parameters**
- `input_size`, 28: image width and height in pixels.
- `cnn_filter_size`, 3: window edge in pixels.
- `cnn_stride`, 2: window step in both dimensions.
- `data_width`, 32: pixel width.
- Derived `out_dim` = (input_size − cnn_filter_size)/cnn_stride + 1, which is 13 at the defaults.

**Ports** (clock and reset first)
- `clk`, input, 1: single clock; all logic samples on the rising edge.
- `rstb`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: pixel present on `in_data`.
- `in_ready`, output, 1: block accepts a pixel this cycle.
- `in_data`, input, data_width: pixel value, raster order (row-major).
- `win_valid`, output, 1: window present on `win_data`.
- `win_ready`, input, 1: consumer takes the window this cycle.
- `win_data`, output, cnn_filter_size²·data_width: window; slot k = ky·cnn_filter_size+kx at bits [k·data_width +: data_width].
- `win_row`, output, clog2(out_dim): window row index.
- `win_col`, output, clog2(out_dim): window column index.
- `win_last`, output, 1: current window is (out_dim−1, out_dim−1).
- `frame_done`, output, 1: one-cycle pulse after the last window handshake.

## Operation

- Two-state FSM: LOAD → SCAN → LOAD.
- **LOAD**
  - `in_ready` = 1 and `win_valid` = 0.
  - Each `in_valid && in_ready` writes `in_data` to `buf[wr_ptr]`, then increments `wr_ptr`.
  - Accepting pixel input_size²−1 clears `wr_ptr` and moves to SCAN.
- **SCAN**
  - `in_ready` = 0 and `win_valid` = 1.
  - Slot (ky,kx) = `buf[(win_row·cnn_stride+ky)·input_size + win_col·cnn_stride+kx]`.
  - On `win_valid && win_ready`, `win_col` increments. At out_dim−1 it wraps to 0 and `win_row` increments.
  - Handshake on the window where `win_last` = 1 clears row/col, pulses `frame_done`, and returns to LOAD.
- `win_data`, `win_row`, `win_col` and `win_last` are driven only from registers. They hold stable while `win_valid && !win_ready`.
- `in_valid` while `in_ready` = 0 is ignored. The upstream source holds its data.
- Buffer contents are not reset. Only the FSM, `wr_ptr`, `win_row`, `win_col` and `frame_done` are reset.
- Arithmetic: `wr_ptr` is clog2(input_size²) bits. Address computation is unsigned and never exceeds input_size²−1 for legal parameters.

## Timing

- Reset: while `rstb` = 0 at an edge, the state becomes LOAD and all counters become 0.
  - `in_ready` = `rstb` && (state==LOAD), so it reads 0 during reset.
  - `win_valid` = 0, `win_last` = 0, `frame_done` = 0.
- Reset mid-LOAD or mid-SCAN aborts the frame. After reset, the next accepted pixel is pixel 0.
- Load latency: input_size² accepted pixels at one pixel per cycle maximum (784 at the defaults).
- Last pixel accepted at edge N → `win_valid` = 1 with window (0,0) in cycle N+1.
- SCAN: one window per cycle while `win_ready` = 1, so out_dim² cycles minimum (169 at the defaults).
- Last window handshake at edge M:
  - `frame_done` = 1 and `in_ready` = 1 in cycle M+1.
  - `frame_done` returns to 0 in cycle M+2.
- Back-to-back frames: no idle cycle is required beyond the LOAD/SCAN alternation. There is no overlap of load and scan.

## Structure

- Package `cnn_pkg` holds:
  - `data_width`;
  - function `out_dim(input_size, filter, stride)`;
  - FSM state enum (LOAD, SCAN).
- Sub-module `cnn_image_buffer`: register array of input_size² × data_width. It has one synchronous write port and cnn_filter_size² combinational read ports addressed by the window base address.
- Top-level `cnn_window_reader` holds the FSM, counters, address generation and handshakes.

## Test plan

1. **Basic frame.** Stream pixels with value = index, `in_valid` = 1 constantly, `win_ready` = 1.
   - Window (0,0) = {0,1,2,28,29,30,56,57,58}.
   - Window (0,1) = {2,3,4,30,31,32,58,59,60}.
   - Window (12,12) = {696,697,698,724,725,726,752,753,754} with `win_last` = 1.
   - Exactly 169 windows, then a `frame_done` pulse.
2. **Backpressure.** Same frame; `win_ready` toggles pseudo-randomly.
   - `win_data`, `win_row` and `win_col` are stable on every stalled cycle.
   - No window is skipped or repeated; the sequence matches scenario 1.
3. **Input gaps.** `in_valid` is asserted one cycle in three.
   - Buffer contents and windows are identical to scenario 1.
   - `win_valid` rises exactly one cycle after the 784th accepted pixel.
4. **Input ignored during SCAN.** Drive `in_valid` = 1 with value 0xDEADBEEF throughout SCAN.
   - `in_ready` = 0 and the windows are unchanged.
   - The next frame (values 1000+index) gives window (0,0) = {1000,1001,1002,1028,...,1058}.
5. **Reset mid-SCAN.** Pulse `rstb` low for 1 cycle after window (3,5).
   - Outputs take reset values.
   - A fresh frame then starts at window (0,0) after 784 new pixels.
6. **Reset mid-LOAD.** Reset after 400 pixels, then send 784 pixels.
   - No window appears before the 784th post-reset pixel.
